pipe_ifq: RTL and testbench

PIPE_IFQ -- requirements
Module: pipe_ifq

---
 rtl/pipe_ifq_pkg.sv | 15 +
 rtl/pipe_ifq_mem.sv | 24 ++
 rtl/pipe_ifq.sv | 71 +++++++
 tb/tb_pipe_ifq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ifq_pkg.sv
// Shared CPU package: datapath width, bubble instruction
// and PC source encodings used by the fetch queue.
package pipe_ifq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_JMP = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/pipe_ifq_mem.sv
// Fetch queue storage: synchronous write port,
// asynchronous read port, no reset on the array.
module pipe_ifq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_ifq.sv
// Instruction fetch queue between IF and ID: holds {pc4, inst}
// entries and is emptied on any redirect from pcsource.
module pipe_ifq
    import pipe_ifq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_inst,
    input  logic              out_ready,
    input  logic [1:0]        pcsource,
    output logic [CW-1:0]     count
);

    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic                push;
    logic                pop;
    logic                flush;
    logic [2*DATA_W-1:0] rdata;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign flush     = (pcsource != PC_SEQ);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A redirect discards the push, so do not write the slot either
    pipe_ifq_mem #(
        .DEPTH (DEPTH),
        .W     (2*DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (tail),
        .wdata ({in_pc4, in_inst}),
        .raddr (head),
        .rdata (rdata)
    );

    assign out_pc4  = out_valid ? rdata[2*DATA_W-1:DATA_W] : '0;
    assign out_inst = out_valid ? rdata[DATA_W-1:0] : NOP_WORD;

endmodule

// File: tb/tb_pipe_ifq.sv
// Self-checking bench for pipe_ifq against a queue model
// of the fetch-queue rules, with directed and random stimulus.
module tb_pipe_ifq;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 0;
    logic        clrn = 0;
    logic        in_valid = 0;
    logic [31:0] in_pc4 = 0;
    logic [31:0] in_inst = 0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic        out_ready = 0;
    logic [1:0]  pcsource = 0;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    logic [63:0] q[$];

    pipe_ifq dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .pcsource  (pcsource),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_pc4();
        return (q.size() != 0) ? q[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_inst();
        return (q.size() != 0) ? q[0][31:0] : NOP;
    endfunction

    // Drive one cycle and advance the model by the queue rules
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic r,
                        input logic [1:0] ps);
        bit psh, pp;
        in_valid = v; in_pc4 = pc; in_inst = inst;
        out_ready = r; pcsource = ps;
        psh = v && (q.size() < DEPTH);
        pp  = r && (q.size() != 0);
        @(posedge clk);
        if (ps != 2'b00) q.delete();
        else begin
            if (pp)  void'(q.pop_front());
            if (psh) q.push_back({pc, inst});
        end
        #1;
        in_valid = 0; out_ready = 0; pcsource = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_pc4 !== 32'h0 || out_inst !== NOP) begin
            failures++;
            $display("FAIL reset cnt=%0d ov=%b ir=%b pc4=%h inst=%h exp 0/0/1/0/%h",
                     count, out_valid, in_ready, out_pc4, out_inst, NOP);
        end
        #5 clrn = 1;
    endtask

    task automatic test_first_push();
        step(1, 32'd4, 32'h2001_0005, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_pc4 !== 32'd4 ||
            out_inst !== 32'h2001_0005 || count !== 3'd1) begin
            failures++;
            $display("FAIL first_push ov=%b pc4=%h inst=%h cnt=%0d exp 1/4/20010005/1",
                     out_valid, out_pc4, out_inst, count);
        end
        step(0, 0, 0, 0, 2'b01);
    endtask

    task automatic test_full();
        logic [31:0] d[5];
        for (int i = 0; i < 5; i++) begin
            d[i] = $urandom;
            step(1, 32'h100 + 32'(4*i), d[i], 0, 0);
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full cnt=%0d ir=%b exp 4/0", count, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_inst !== d[i] || out_pc4 !== 32'h100 + 32'(4*i)) begin
                failures++;
                $display("FAIL full_order i=%0d got=%h/%h exp=%h/%h",
                         i, out_pc4, out_inst, 32'h100 + 32'(4*i), d[i]);
            end
            step(0, 0, 0, 1, 0);
        end
        checks++;
        if (count !== 3'd0 || out_inst !== NOP || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drained cnt=%0d ov=%b inst=%h exp 0/0/%h",
                     count, out_valid, out_inst, NOP);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        step(1, 32'h10, a, 0, 0);
        step(1, 32'h14, b, 0, 0);
        step(1, 32'h18, c, 1, 0);
        checks++;
        if (count !== 3'd2 || out_inst !== b || out_pc4 !== 32'h14) begin
            failures++;
            $display("FAIL push_pop cnt=%0d head=%h/%h exp 2/14/%h",
                     count, out_pc4, out_inst, b);
        end
        step(0, 0, 0, 0, 2'b01);
    endtask

    task automatic test_flush();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) step(1, 32'(i), $urandom, 0, 0);
        step(1, 32'h77, 32'h77, 1, 2'b01);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'h0 ||
            out_pc4 !== 32'h0) begin
            failures++;
            $display("FAIL flush cnt=%0d ov=%b pc4=%h inst=%h exp 0/0/0/0",
                     count, out_valid, out_pc4, out_inst);
        end
        e = $urandom;
        step(1, 32'h200, e, 0, 0);
        checks++;
        if (count !== 3'd1 || out_inst !== e || out_pc4 !== 32'h200) begin
            failures++;
            $display("FAIL after_flush cnt=%0d head=%h/%h exp 1/200/%h",
                     count, out_pc4, out_inst, e);
        end
        step(0, 0, 0, 0, 2'b10);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            step(1, 32'h300 + 32'(i), d, 0, 0);
            if (out_inst !== d || out_pc4 !== 32'h300 + 32'(i) || count > 3'd4) begin
                bad++;
                $display("FAIL wrap i=%0d got=%h/%h cnt=%0d exp=%h/%h",
                         i, out_pc4, out_inst, count, 32'h300 + 32'(i), d);
            end
            step(0, 0, 0, 1, 0);
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_async_reset();
        step(1, 32'h40, $urandom, 0, 0);
        step(1, 32'h44, $urandom, 0, 0);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset cnt=%0d exp 2", count);
        end
        #2 clrn = 0;
        q.delete();
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_pc4 !== 32'h0 || out_inst !== NOP) begin
            failures++;
            $display("FAIL async_reset cnt=%0d ov=%b ir=%b pc4=%h inst=%h",
                     count, out_valid, in_ready, out_pc4, out_inst);
        end
        #3 clrn = 1;
        step(1, 32'h50, 32'hABCD_0001, 0, 0);
        checks++;
        if (count !== 3'd1 || out_inst !== 32'hABCD_0001) begin
            failures++;
            $display("FAIL post_reset_push cnt=%0d inst=%h exp 1/abcd0001",
                     count, out_inst);
        end
        step(0, 0, 0, 0, 2'b11);
    endtask

    task automatic test_random();
        logic [1:0] ps;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid !== (q.size() != 0) ||
                in_ready !== (q.size() != DEPTH) ||
                count !== 3'(q.size()) ||
                out_pc4 !== exp_pc4() || out_inst !== exp_inst()) begin
                bad++;
                if (bad < 10)
                    $display("FAIL random cyc=%0d cnt=%0d/%0d ov=%b ir=%b head=%h/%h exp %h/%h",
                             i, count, q.size(), out_valid, in_ready,
                             out_pc4, out_inst, exp_pc4(), exp_inst());
            end
            ps = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), ps);
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_full();
        test_push_pop();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
